uart_port_arbiter: RTL and testbench
====================================

UART_PORT_ARBITER -- requirements
Module: uart_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of all data buses.
REQ-002 Parameter READ_LAT, default 1, legal 1..4: UART slave read-data latency in cycles after the read strobe.
REQ-003 Parameter LOCK_MAX, default 8: maximum consecutive locked grants to one master.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mN_read, mN_write  input  1 each (N=0,1)  master N request strobes; held until its waitrequest is sampled low.
REQ-007 mN_writedata  input  DATA_W  master N write data; stable while the request is held.
REQ-008 mN_lock  input  1  master N asks to keep the grant for its next transaction.
REQ-009 mN_waitrequest  output  1  high while master N's request is pending.
REQ-010 mN_readdata  output  DATA_W  read data to master N; valid in its read completion cycle.
REQ-011 read, write, chip_select  output  1 each  UART slave port strobes.
REQ-012 writedata  output  DATA_W  UART slave write data.
REQ-013 readdata  input  DATA_W  UART slave read data.
REQ-014 estado  output  2  current FSM state, for debug.

Function
REQ-015 FSM states SHALL be IDLE=00, ACCESS=01, RWAIT=10, RDONE=11.
REQ-016 In IDLE with at least one request, the arbiter SHALL latch the winner, direction and writedata, then enter ACCESS.
REQ-017 Simultaneous requests SHALL be resolved round-robin: the master not granted last wins.
REQ-018 A master asserting read and write together SHALL be treated as a write.
REQ-019 In ACCESS, chip_select SHALL be high for exactly one cycle, together with the latched read or write strobe and the latched writedata.
REQ-020 For a write, the ACCESS cycle SHALL be the completion cycle; FSM then returns to IDLE. Write request sampled at edge t completes in cycle t+1.
REQ-021 For a read, RWAIT SHALL last READ_LAT cycles, and readdata SHALL be captured at the last RWAIT edge.
REQ-022 RDONE SHALL be the read completion cycle, driving the captured data on mN_readdata; FSM then returns to IDLE. Read request sampled at edge t completes in cycle t+2+READ_LAT.
REQ-023 mN_waitrequest SHALL equal (mN_read|mN_write) AND NOT (master N's completion cycle); this path is combinational.
REQ-024 Strobes SHALL be low in every state except ACCESS. The ungranted master's readdata SHALL hold its previous value.
REQ-025 A request dropped before grant SHALL be ignored. A request dropped after grant SHALL NOT abort the access.
REQ-026 Minimum spacing between back-to-back grants SHALL be one IDLE cycle.

Reset
REQ-027 Asserting reset at any time, including mid-access, SHALL force: IDLE; read, write and chip_select = 0; writedata = 0; both mN_readdata = 0; last-grant = master 1, so master 0 wins the first tie; lock counter = 0.
REQ-028 An interrupted access SHALL NOT be completed or replayed after reset.

Configuration
REQ-029 With macro UART_ARB_LOCK_EN defined: if the owner holds mN_lock high in its completion cycle and is requesting in the following IDLE, it SHALL be re-granted regardless of round-robin, up to LOCK_MAX consecutive grants. After that the other master, if requesting, wins.
REQ-030 With UART_ARB_LOCK_EN undefined, mN_lock SHALL be ignored and no lock counter synthesised.

Structure
REQ-031 Package uart_arb_pkg SHALL hold the state enum and encodings, the master-index type and the READ_LAT bounds.
REQ-032 The 2-way round-robin pick SHALL be sub-module uart_rr_picker (inputs: requests, last grant, lock override; output: winner).

Verification
REQ-033 m0 writes 0x0000_00A5 alone -> chip_select, write and writedata=0xA5 high one cycle later; m0_waitrequest low that same cycle.
REQ-034 m1 reads, READ_LAT=2, slave returns 0x1234_5678 two cycles after the strobe -> m1_readdata=0x12345678 with m1_waitrequest low 4 cycles after request.
REQ-035 m0 and m1 request continuously for 4 transactions after reset -> grant order m0, m1, m0, m1.
REQ-036 UART_ARB_LOCK_EN, LOCK_MAX=3, m0 locked and m1 requesting -> grants m0, m0, m0, m1. Without the macro -> m0, m1, m0, m1.
REQ-037 reset pulsed during RWAIT -> strobes low and estado=00 immediately; no completion on either master; the next request is served normally.
REQ-038 m0 asserts read and write together with writedata 0x5A -> single slave write of 0x5A; no read strobe.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types for the two-master UART port arbiter: FSM encoding,
// master index type and the legal read-latency range.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RWAIT  = 2'b10,
        RDONE  = 2'b11
    } state_t;

    typedef logic master_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;
    localparam int LAT_CNT_W    = $clog2(READ_LAT_MAX);

endpackage

// File: rtl/uart_rr_picker.sv
// Two-way round-robin winner selection with an optional "keep the last
// owner" override used by the lock feature.
module uart_rr_picker
    import uart_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_t    last_grant,
    input  logic       lock_override,
    output master_t    winner
);

    // The other master has priority unless the previous owner keeps its lock.
    always_comb begin
        winner = last_grant;
        if (lock_override && req[last_grant]) begin
            winner = last_grant;
        end else if (req[~last_grant]) begin
            winner = ~last_grant;
        end
    end

endmodule

// File: rtl/uart_port_arbiter.sv
// Arbitrates two masters onto one UART slave port (single-cycle strobe,
// READ_LAT read latency). Optional lock feature: macro UART_ARB_LOCK_EN.
module uart_port_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              read,
    output logic              write,
    output logic              chip_select,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic [1:0]        estado
);

    state_t                 state;
    state_t                 state_next;
    master_t                owner;
    master_t                last_grant;
    master_t                winner;
    logic                   dir_write;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      rdata0_q;
    logic [DATA_W-1:0]      rdata1_q;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic [1:0]             req;
    logic                   lock_override;
    logic                   completing;
    logic                   grant;

    assign req   = {m1_read | m1_write, m0_read | m0_write};
    assign grant = (state == IDLE) && (|req);

    uart_rr_picker u_picker (
        .req           (req),
        .last_grant    (last_grant),
        .lock_override (lock_override),
        .winner        (winner)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        completing = 1'b0;
        case (state)
            IDLE: begin
                if (|req) state_next = ACCESS;
            end
            ACCESS: begin
                completing = dir_write;
                state_next = dir_write ? IDLE : RWAIT;
            end
            RWAIT: begin
                if (lat_cnt == '0) state_next = RDONE;
            end
            RDONE: begin
                completing = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A master driving read and write together is served as a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            dir_write  <= 1'b0;
            wdata_q    <= '0;
            lat_cnt    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner      <= winner;
                        last_grant <= winner;
                        dir_write  <= winner ? m1_write : m0_write;
                        wdata_q    <= winner ? m1_writedata : m0_writedata;
                    end
                end
                ACCESS: begin
                    lat_cnt <= LAT_CNT_W'(READ_LAT - 1);
                end
                RWAIT: begin
                    if (lat_cnt == '0) begin
                        if (owner) rdata1_q <= readdata;
                        else       rdata0_q <= readdata;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UART_ARB_LOCK_EN
    localparam int LOCK_CW = $clog2(LOCK_MAX + 1);

    logic [LOCK_CW-1:0] lock_cnt;
    logic               lock_pending;
    logic               owner_lock;

    assign owner_lock    = owner ? m1_lock : m0_lock;
    assign lock_override = lock_pending && (lock_cnt < LOCK_CW'(LOCK_MAX));

    // lock_cnt counts consecutive grants to last_grant and saturates at LOCK_MAX.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_cnt     <= '0;
            lock_pending <= 1'b0;
        end else begin
            if (completing) begin
                lock_pending <= owner_lock;
            end else if (grant) begin
                lock_pending <= 1'b0;
            end
            if (grant) begin
                if (winner == last_grant) begin
                    if (lock_cnt != LOCK_CW'(LOCK_MAX)) lock_cnt <= lock_cnt + 1'b1;
                end else begin
                    lock_cnt <= LOCK_CW'(1);
                end
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock   = ^{m0_lock, m1_lock, LOCK_MAX};
    assign lock_override = 1'b0;
`endif

    assign chip_select    = (state == ACCESS);
    assign write          = chip_select & dir_write;
    assign read           = chip_select & ~dir_write;
    assign writedata      = wdata_q;
    assign estado         = state;
    assign m0_readdata    = rdata0_q;
    assign m1_readdata    = rdata1_q;
    assign m0_waitrequest = req[0] & ~(completing & (owner == 1'b0));
    assign m1_waitrequest = req[1] & ~(completing & (owner == 1'b1));

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Self-checking bench for uart_port_arbiter (READ_LAT=2, LOCK_MAX=3);
// expected grant order follows UART_ARB_LOCK_EN when it is defined.
module tb_uart_port_arbiter;

    localparam int DATA_W   = 32;
    localparam int READ_LAT = 2;
    localparam int LOCK_MAX = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              m0_read, m0_write, m0_lock, m0_waitrequest;
    logic              m1_read, m1_write, m1_lock, m1_waitrequest;
    logic [DATA_W-1:0] m0_writedata, m0_readdata, m1_writedata, m1_readdata;
    logic              read, write, chip_select;
    logic [DATA_W-1:0] writedata, readdata;
    logic [1:0]        estado;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          master;
        logic [2:0]  flags;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        int          master;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic [2:0]  exp_flags;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[8];

    uart_port_arbiter #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_lock        (m0_lock),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_lock        (m1_lock),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .read           (read),
        .write          (write),
        .chip_select    (chip_select),
        .writedata      (writedata),
        .readdata       (readdata),
        .estado         (estado)
    );

    always #5 clock = ~clock;

    // Slave model: read data is valid only READ_LAT cycles after the strobe.
    int          rd_age = 99;
    logic [31:0] slave_val = 32'h0;

    always @(posedge clock or posedge reset) begin
        if (reset) rd_age <= 99;
        else if (read && chip_select) rd_age <= 1;
        else if (rd_age < 99) rd_age <= rd_age + 1;
    end

    assign readdata = (rd_age == READ_LAT) ? slave_val : 32'hDEADBEEF;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(int master, logic [2:0] flags, logic [31:0] data);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected: m%0d completed flags %b data %h with nothing expected",
                     master, flags, data);
        end else begin
            e = sb.pop_front();
            if (e.master != master || e.flags !== flags || e.data !== data) begin
                errors++;
                $display("[TB] FAIL sb_compare: got m%0d flags %b data %h expected m%0d flags %b data %h",
                         master, flags, data, e.master, e.flags, e.data);
            end
        end
    endtask

    // Completion monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            if ((m0_read | m0_write) && !m0_waitrequest)
                checkOutput(0, {chip_select, read, write}, chip_select ? writedata : m0_readdata);
            if ((m1_read | m1_write) && !m1_waitrequest)
                checkOutput(1, {chip_select, read, write}, chip_select ? writedata : m1_readdata);
        end
    end

    task automatic setReq(int m, logic rd, logic wr, logic [31:0] wd, logic lk);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_writedata = wd; m0_lock = lk;
        end else begin
            m1_read = rd; m1_write = wr; m1_writedata = wd; m1_lock = lk;
        end
    endtask

    function automatic logic getWait(int m);
        return (m == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    task automatic applyStimulus(vec_t v);
        int lat = 0;
        bit done = 0;
        sb.push_back('{v.master, v.exp_flags, v.exp_data});
        slave_val = v.sdata;
        @(negedge clock); #1;
        setReq(v.master, v.rd, v.wr, v.wdata, 1'b0);
        while (!done && lat < 20) begin
            @(negedge clock); #1;
            lat++;
            if (!getWait(v.master)) done = 1;
        end
        setReq(v.master, 1'b0, 1'b0, 32'h0, 1'b0);
        check("latency", lat, v.exp_lat);
    endtask

    task automatic runMaster(int m, int n, logic lk);
        for (int i = 0; i < n; i++) begin
            int cyc = 0;
            bit done = 0;
            setReq(m, 1'b0, 1'b1, ((m == 0) ? 32'h100 : 32'h200) + i, lk);
            while (!done && cyc < 50) begin
                @(negedge clock); #1;
                cyc++;
                if (!getWait(m)) done = 1;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("[TB] FAIL rr_timeout: m%0d txn %0d not served", m, i);
            end
        end
        setReq(m, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic pulseReset();
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic runPair(logic lk, int order_m[6], logic [31:0] order_d[6]);
        pulseReset();
        for (int i = 0; i < 6; i++) sb.push_back('{order_m[i], 3'b101, order_d[i]});
        @(negedge clock); #1;
        fork
            runMaster(0, 4, lk);
            runMaster(1, 2, 1'b0);
        join
        @(negedge clock); #1;
        check("pair_drained", sb.size(), 0);
    endtask

    initial begin
        int          rr_m[6]  = '{0, 1, 0, 1, 0, 0};
        logic [31:0] rr_d[6]  = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h103};
`ifdef UART_ARB_LOCK_EN
        int          lk_m[6]  = '{0, 0, 0, 1, 0, 1};
        logic [31:0] lk_d[6]  = '{32'h100, 32'h101, 32'h102, 32'h200, 32'h103, 32'h201};
`else
        int          lk_m[6]  = '{0, 1, 0, 1, 0, 0};
        logic [31:0] lk_d[6]  = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h103};
`endif
        vec_t        tail;

        vecs[0] = '{0, 1'b0, 1'b1, 32'h000000A5, 32'h0,        3'b101, 32'h000000A5, 1};
        vecs[1] = '{1, 1'b1, 1'b0, 32'h0,        32'h12345678, 3'b000, 32'h12345678, 4};
        vecs[2] = '{0, 1'b1, 1'b1, 32'h0000005A, 32'h11111111, 3'b101, 32'h0000005A, 1};
        vecs[3] = '{1, 1'b0, 1'b1, 32'hCAFEF00D, 32'h0,        3'b101, 32'hCAFEF00D, 1};
        vecs[4] = '{0, 1'b1, 1'b0, 32'hFFFF0000, 32'h0BADF00D, 3'b000, 32'h0BADF00D, 4};
        vecs[5] = '{1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,        3'b101, 32'hFFFFFFFF, 1};
        vecs[6] = '{0, 1'b0, 1'b1, 32'h0,        32'h0,        3'b101, 32'h0,        1};
        vecs[7] = '{1, 1'b1, 1'b0, 32'h0,        32'h80000001, 3'b000, 32'h80000001, 4};

        reset = 1'b1;
        setReq(0, 1'b0, 1'b0, 32'h0, 1'b0);
        setReq(1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check("rst_estado", estado, 2'b00);
        check("rst_strobes", {chip_select, read, write}, 3'b000);
        check("rst_writedata", writedata, 32'h0);
        check("rst_m0_readdata", m0_readdata, 32'h0);
        check("rst_m1_readdata", m1_readdata, 32'h0);
        check("rst_waitreq", {m1_waitrequest, m0_waitrequest}, 2'b00);
        @(negedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
        check("m0_readdata_hold", m0_readdata, 32'h0BADF00D);

        runPair(1'b0, rr_m, rr_d);
        runPair(1'b1, lk_m, lk_d);

        // Request dropped right after its grant still runs to completion.
        slave_val = 32'h600DCAFE;
        @(negedge clock); #1;
        setReq(0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clock); #1;
        setReq(0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clock);
        #1;
        check("drop_estado", estado, 2'b11);
        check("drop_readdata", m0_readdata, 32'h600DCAFE);

        // Reset in the middle of a read: nothing completes or replays.
        slave_val = 32'h55AA55AA;
        @(negedge clock); #1;
        setReq(1, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clock);
        #1;
        check("mid_estado", estado, 2'b10);
        reset = 1'b1;
        #1;
        check("midrst_estado", estado, 2'b00);
        check("midrst_strobes", {chip_select, read, write}, 3'b000);
        check("midrst_m0_readdata", m0_readdata, 32'h0);
        check("midrst_waitreq", m1_waitrequest, 1'b1);
        setReq(1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clock); #1;
        reset = 1'b0;
        repeat (6) @(negedge clock);
        #1;
        check("norep_estado", estado, 2'b00);
        check("norep_m1_readdata", m1_readdata, 32'h0);
        tail = '{0, 1'b0, 1'b1, 32'h00000077, 32'h0, 3'b101, 32'h00000077, 1};
        applyStimulus(tail);

        @(negedge clock); #1;
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
